// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Optional watchdog abort on a stuck transmitter: define TXARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_din,
  output logic              tx_din_rdy,
  input  logic              tx_rdy,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE, LAUNCH, WAIT_ACK, WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      din_q, din_d;
  logic            din_rdy_q, din_rdy_d;
  logic            found, launch, waiting, timeout;

  // Search starts one past the last owner, wrapping at NREQ.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign launch    = (state_q == IDLE) && tx_rdy && found;
  assign req_ready = launch ? win_oh : '0;
  assign waiting   = (state_q == WAIT_ACK) || (state_q == WAIT_DONE);

`ifdef TXARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q;

  assign timeout = waiting && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == LAUNCH) cnt_d = '0;
    else if (waiting)      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end

  assign err = err_q;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (launch) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_ACK;
      WAIT_ACK:  if (timeout)      state_d = IDLE;
                 else if (!tx_rdy) state_d = WAIT_DONE;
      WAIT_DONE: if (timeout || tx_rdy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Strobe is high exactly while waiting for the transmitter's ack.
  always_comb begin
    din_d     = launch ? req_data[8*int'(win) +: 8] : din_q;
    din_rdy_d = (state_d == WAIT_ACK);
    cur_d     = launch ? win : cur_q;
    grant_d   = launch ? win_oh
              : (state_d == IDLE) ? '0 : grant_q;
    last_d    = (waiting && state_d == IDLE) ? cur_q : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q     <= '0;
      din_rdy_q <= 1'b0;
      grant_q   <= '0;
      cur_q     <= '0;
      last_q    <= IW'(NREQ - 1);
    end else begin
      din_q     <= din_d;
      din_rdy_q <= din_rdy_d;
      grant_q   <= grant_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
    end
  end

  assign tx_din     = din_q;
  assign tx_din_rdy = din_rdy_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NREQ=2.
// Timeout scenario switches on TXARB_TIMEOUT_EN (TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [7:0]  tx_din;
  logic        tx_din_rdy;
  logic        tx_rdy = 1'b1;
  logic [1:0]  grant;
  logic        busy;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  uart_tx_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_din(tx_din),
    .tx_din_rdy(tx_din_rdy), .tx_rdy(tx_rdy),
    .grant(grant), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; tx_rdy = 1'b1;
    step(); step();
    n_total++;
    if ({tx_din, tx_din_rdy, grant, busy, err} !== 13'd0)
      $display("FAIL reset_outs got %h/%b/%b/%b/%b want 0",
               tx_din, tx_din_rdy, grant, busy, err);
    else n_pass++;
    rst = 1'b0;
    step();
    n_total++;
    if (req_ready !== 2'b00 || busy !== 1'b0)
      $display("FAIL reset_idle got rdy=%b busy=%b want 00/0",
               req_ready, busy);
    else n_pass++;
  endtask

  task automatic test_single;
    req_data = 16'h00A5; req_valid = 2'b01;
    #1;
    n_total++;
    if (req_ready !== 2'b01)
      $display("FAIL single_ready got %b want 01", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    #1;
    n_total++;
    if (tx_din !== 8'hA5 || grant !== 2'b01 || busy !== 1'b1
        || tx_din_rdy !== 1'b0 || req_ready !== 2'b00)
      $display("FAIL single_launch got %h/%b/%b/%b want a5/01/1/0",
               tx_din, grant, busy, tx_din_rdy);
    else n_pass++;
    step();
    n_total++;
    if (tx_din_rdy !== 1'b1 || tx_din !== 8'hA5)
      $display("FAIL single_dinrdy got %b/%h want 1/a5",
               tx_din_rdy, tx_din);
    else n_pass++;
    step();
    n_total++;
    if (tx_din_rdy !== 1'b1)
      $display("FAIL single_hold got %b want 1", tx_din_rdy);
    else n_pass++;
    tx_rdy = 1'b0;
    step();
    n_total++;
    if (tx_din_rdy !== 1'b0 || busy !== 1'b1 || grant !== 2'b01)
      $display("FAIL single_ack got %b/%b/%b want 0/1/01",
               tx_din_rdy, busy, grant);
    else n_pass++;
    tx_rdy = 1'b1;
    step();
    n_total++;
    if (busy !== 1'b0 || grant !== 2'b00 || err !== 1'b0)
      $display("FAIL single_done got %b/%b/%b want 0/00/0",
               busy, grant, err);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1; step(); rst = 1'b0; step();
    req_data = 16'h2211; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (req_ready !== exp_g[i])
        $display("FAIL rr_ready[%0d] got %b want %b",
                 i, req_ready, exp_g[i]);
      else n_pass++;
      step();
      n_total++;
      if (tx_din !== exp_d[i] || grant !== exp_g[i])
        $display("FAIL rr_data[%0d] got %h/%b want %h/%b",
                 i, tx_din, grant, exp_d[i], exp_g[i]);
      else n_pass++;
      step();
      n_total++;
      if (tx_din_rdy !== 1'b1 || req_ready !== 2'b00)
        $display("FAIL rr_wait[%0d] got %b/%b want 1/00",
                 i, tx_din_rdy, req_ready);
      else n_pass++;
      tx_rdy = 1'b0; step();
      tx_rdy = 1'b1; step();
      n_total++;
      if (grant !== 2'b00 || busy !== 1'b0)
        $display("FAIL rr_done[%0d] got %b/%b want 00/0",
                 i, grant, busy);
      else n_pass++;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_tx_busy_idle;
    tx_rdy = 1'b0; req_data = 16'h0033; req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (req_ready !== 2'b00 || busy !== 1'b0)
        $display("FAIL txbusy_hold[%0d] got %b/%b want 00/0",
                 i, req_ready, busy);
      else n_pass++;
      step();
    end
    tx_rdy = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b01)
      $display("FAIL txbusy_ready got %b want 01", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    n_total++;
    if (busy !== 1'b1 || tx_din !== 8'h33)
      $display("FAIL txbusy_launch got %b/%h want 1/33", busy, tx_din);
    else n_pass++;
    step();
    tx_rdy = 1'b0; step();
    tx_rdy = 1'b1; step();
  endtask

  task automatic test_reset_mid;
    req_data = 16'h5544; req_valid = 2'b11;
    #1;
    n_total++;
    if (req_ready !== 2'b10)
      $display("FAIL mid_ready got %b want 10", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    step();
    tx_rdy = 1'b0;
    step();
    n_total++;
    if (busy !== 1'b1 || grant !== 2'b10)
      $display("FAIL mid_waitdone got %b/%b want 1/10", busy, grant);
    else n_pass++;
    rst = 1'b1;
    step();
    n_total++;
    if (tx_din_rdy !== 1'b0 || grant !== 2'b00 || busy !== 1'b0)
      $display("FAIL mid_rst got %b/%b/%b want 0/00/0",
               tx_din_rdy, grant, busy);
    else n_pass++;
    rst = 1'b0; tx_rdy = 1'b1; req_valid = 2'b11;
    #1;
    n_total++;
    if (req_ready !== 2'b01)
      $display("FAIL mid_last got %b want 01", req_ready);
    else n_pass++;
    req_valid = 2'b10;
    #1;
    n_total++;
    if (req_ready !== 2'b10)
      $display("FAIL mid_req1 got %b want 10", req_ready);
    else n_pass++;
    step();
    req_valid = 2'b00;
    n_total++;
    if (tx_din !== 8'h55 || grant !== 2'b10)
      $display("FAIL mid_serve got %h/%b want 55/10", tx_din, grant);
    else n_pass++;
    step();
    tx_rdy = 1'b0; step();
    tx_rdy = 1'b1; step();
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL mid_idle got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_timeout;
    tx_rdy = 1'b1; req_data = 16'h0066; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
`ifdef TXARB_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      step();
      n_total++;
      if (busy !== 1'b1 || err !== 1'b0)
        $display("FAIL to_wait[%0d] got %b/%b want 1/0", k, busy, err);
      else n_pass++;
    end
    step();
    n_total++;
    if (err !== 1'b1 || tx_din_rdy !== 1'b0 || busy !== 1'b0
        || grant !== 2'b00)
      $display("FAIL to_fire got %b/%b/%b/%b want 1/0/0/00",
               err, tx_din_rdy, busy, grant);
    else n_pass++;
    step();
    n_total++;
    if (err !== 1'b0)
      $display("FAIL to_pulse got %b want 0", err);
    else n_pass++;
`else
    for (int k = 1; k <= 20; k++) step();
    n_total++;
    if (busy !== 1'b1 || tx_din_rdy !== 1'b1 || err !== 1'b0)
      $display("FAIL nto_wait got %b/%b/%b want 1/1/0",
               busy, tx_din_rdy, err);
    else n_pass++;
    tx_rdy = 1'b0; step();
    tx_rdy = 1'b1; step();
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL nto_done got %b want 0", busy);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tx_busy_idle();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
